piccolo80_key_sched: RTL
========================

// Module: piccolo80_key_sched
// PURPOSE
//  Sequential Piccolo-80 key schedule; directly upstream of the round datapath (piccoloenc chain).
//  Latches an 80-bit key and presents the whitening keys wk0..wk3.
//  Streams the 25 round-key pairs (rk2i|rk2i+1) one per valid/ready handshake, replacing the hard-wired keyin.
// PARAMETERS
//  ROUNDS   25             number of round-key pairs emitted (Piccolo-80 = 25)
//  CON_XOR  32'h0f1e2d3c   constant XORed into every con80 word
// PORTS
//  clk       in   1    rising-edge clock
//  reset     in   1    asynchronous, active-low reset
//  key_load  in   1    1-cycle request to latch key_in and start a schedule
//  key_in    in   80   key k0..k4 (16b each), bit 0 = MSB of k0
//  wk        out  64   {wk0,wk1,wk2,wk3} registered whitening keys
//  rk_valid  out  1    rk_out holds a valid round-key pair
//  rk_ready  in   1    round datapath accepts rk_out
//  rk_out    out  32   {rk2i, rk2i+1} for round rk_round
//  rk_round  out  5    index i of current pair (0..ROUNDS-1)
//  rk_last   out  1    rk_out is pair ROUNDS-1
//  busy      out  1    schedule in progress (state RUN)
//  done      out  1    all ROUNDS pairs accepted; level until next load
// BEHAVIOUR
//  Reset (async, reset==0): state IDLE; key reg, wk, rk_out = 0; rk_round = 0; mod5 counter = 0.
//    Reset also forces rk_valid, rk_last, busy and done to 0.
//  Whitening, set on load: wk0 = k0[0:7]|k1[8:15], wk1 = k1[0:7]|k0[8:15].
//    wk2 = k4[0:7]|k3[8:15], wk3 = k3[0:7]|k4[8:15].
//    wk holds its value until the next accepted load.
//  con80(i) = {c,5'b0,c,2'b0,c,5'b0,c} ^ CON_XOR, where c = 5-bit (i+1).
//  rk_out(i) = con80(i) ^ sel, selected by m = i mod 5:
//    m in {0,2}: sel = {k2,k3}; m in {1,4}: sel = {k0,k1}; m = 3: sel = {k4,k4}.
//  m is kept as a separate wrapping 0..4 counter (no divider); it advances with rk_round.
//  States: IDLE -> RUN on key_load; RUN -> DONE on handshake with rk_last; DONE -> RUN on key_load.
//  Load latency: key_load in cycle T -> wk, rk_out(0), rk_valid=1, busy=1 registered at T+1.
//  Handshake: a transfer occurs in any cycle where rk_valid && rk_ready.
//    rk_out, rk_round and rk_last stay stable while rk_valid && !rk_ready.
//    On a transfer with i < ROUNDS-1: the next cycle shows pair i+1 (back-to-back, 1 pair/clk).
//    On a transfer with i = ROUNDS-1: next cycle rk_valid=0, busy=0, done=1.
//    rk_round and m wrap to 0 at that point.
//  rk_last = (rk_round == ROUNDS-1) && rk_valid.
//  key_load in IDLE or DONE always accepted; done clears in the same cycle that busy rises.
//  key_load in RUN: see CONFIGURATION.
//  rk_ready while rk_valid=0 is ignored.
//  Reset asserted mid-schedule aborts immediately; no partial pair is left valid.
// CONFIGURATION
//  PICCOLO_KS_REKEY_EN defined: key_load in RUN aborts the current schedule.
//    It relatches key/wk and restarts at i=0 at T+1, as a fresh load.
//    It takes priority over a simultaneous transfer, which is discarded and does not advance.
//  PICCOLO_KS_REKEY_EN undefined: key_load in RUN is ignored.
//    The key register, wk and the pair sequence are unaffected.
// TESTING
//  T1 reset=0 mid-sim -> all outputs 0 asynchronously, before the next clk edge.
//  T2 load key 80'h00112233445566778899 -> wk = 64'h0033_2211_8877_6699.
//    Also rk_out = 32'h43494f4a, rk_round = 0, rk_valid = 1, one cycle after load.
//  T3 same key, rk_ready=1 constantly -> 25 pairs on 25 consecutive clocks.
//    Pair i=3 is 32'ha78fb5a1; rk_last is high only on i=24; done=1 on the cycle after.
//  T4 rk_ready toggled pseudo-randomly -> identical 25-pair sequence; no pair dropped or duplicated.
//    rk_out is stable whenever stalled.
//  T5 key_load at i=10 with key 80'h0 -> REKEY_EN: next cycle i=0, rk_out = 32'h071c293d.
//    Without REKEY_EN: the sequence continues at i=11 with the old key.
//  T6 key_load in DONE -> done drops and busy rises at T+1; the sequence restarts at i=0.

Source files
------------

// File: rtl/piccolo80_key_sched_if.sv
// ============================================================================
// piccolo80_key_sched_if : key load / whitening / round-key stream bundle
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface piccolo80_key_sched_if;
    logic        key_load;
    logic [79:0] key_in;
    logic [63:0] wk;
    logic        rk_valid;
    logic        rk_ready;
    logic [31:0] rk_out;
    logic [4:0]  rk_round;
    logic        rk_last;
    logic        busy;
    logic        done;

    // master = key schedule (source of the round-key stream)
    modport master (
        input  key_load, key_in, rk_ready,
        output wk, rk_valid, rk_out, rk_round, rk_last, busy, done
    );

    modport slave (
        output key_load, key_in, rk_ready,
        input  wk, rk_valid, rk_out, rk_round, rk_last, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/piccolo80_key_sched.sv
// ============================================================================
// piccolo80_key_sched : sequential Piccolo-80 key schedule (wk0..wk3 + 25 rk pairs)
// Option macro PICCOLO_KS_REKEY_EN: key_load during RUN restarts the schedule.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module piccolo80_key_sched #(
    parameter int          ROUNDS  = 25,
    parameter logic [31:0] CON_XOR = 32'h0f1e2d3c
) (
    input  wire logic clk,
    input  wire logic reset,
    piccolo80_key_sched_if.master ks
);

    localparam logic [4:0] LAST_IDX = 5'(ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [79:0] key_q, key_d;
    logic [63:0] wk_q, wk_d;
    logic [31:0] rk_out_q, rk_out_d;
    logic [4:0]  rk_round_q, rk_round_d;
    logic [2:0]  m_q, m_d;

    logic        load_ok;
    logic        xfer;
    logic [2:0]  m_inc;

    // key k0..k4 sits MSB-first: k0 = key[79:64], k4 = key[15:0]
    function automatic logic [31:0] rk_calc(input logic [4:0]  idx,
                                            input logic [2:0]  m,
                                            input logic [79:0] k);
        logic [4:0]  c;
        logic [31:0] con;
        logic [31:0] sel;
        c   = idx + 5'd1;
        con = {c, 5'b0, c, 2'b0, c, 5'b0, c} ^ CON_XOR;
        case (m)
            3'd0, 3'd2: sel = k[47:16];
            3'd1, 3'd4: sel = k[79:48];
            default:    sel = {k[15:0], k[15:0]};
        endcase
        return con ^ sel;
    endfunction

`ifdef PICCOLO_KS_REKEY_EN
    assign load_ok = ks.key_load;
`else
    assign load_ok = ks.key_load && (state_q != S_RUN);
`endif

    assign xfer  = (state_q == S_RUN) && ks.rk_ready;
    assign m_inc = (m_q == 3'd4) ? 3'd0 : m_q + 3'd1;

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        wk_d       = wk_q;
        rk_out_d   = rk_out_q;
        rk_round_d = rk_round_q;
        m_d        = m_q;

        // A load wins over a simultaneous transfer; that transfer is dropped.
        if (load_ok) begin
            state_d    = S_RUN;
            key_d      = ks.key_in;
            wk_d       = {ks.key_in[79:72], ks.key_in[55:48],
                          ks.key_in[63:56], ks.key_in[71:64],
                          ks.key_in[15:8],  ks.key_in[23:16],
                          ks.key_in[31:24], ks.key_in[7:0]};
            rk_round_d = 5'd0;
            m_d        = 3'd0;
            rk_out_d   = rk_calc(5'd0, 3'd0, ks.key_in);
        end else if (xfer) begin
            if (rk_round_q == LAST_IDX) begin
                state_d    = S_DONE;
                rk_round_d = 5'd0;
                m_d        = 3'd0;
            end else begin
                rk_round_d = rk_round_q + 5'd1;
                m_d        = m_inc;
                rk_out_d   = rk_calc(rk_round_q + 5'd1, m_inc, key_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            key_q      <= '0;
            wk_q       <= '0;
            rk_out_q   <= '0;
            rk_round_q <= '0;
            m_q        <= '0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            wk_q       <= wk_d;
            rk_out_q   <= rk_out_d;
            rk_round_q <= rk_round_d;
            m_q        <= m_d;
        end
    end

    assign ks.wk       = wk_q;
    assign ks.rk_out   = rk_out_q;
    assign ks.rk_round = rk_round_q;
    assign ks.rk_valid = (state_q == S_RUN);
    assign ks.busy     = (state_q == S_RUN);
    assign ks.done     = (state_q == S_DONE);
    assign ks.rk_last  = (state_q == S_RUN) && (rk_round_q == LAST_IDX);

endmodule

`default_nettype wire
